// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, mandatory parity, one or two stop bits,
// with a small read-only register window for data and sticky status flags.
module uart_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic        Rx_in,
    input  logic [13:0] baud_divisor,
    input  logic        Rx_en,
    input  logic        Two_stop,
    input  logic        Odd_parity,
    input  logic [31:0] addr,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        rx_valid
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2
    } state_t;

    state_t      state_q;
    logic [13:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        perr_q;
    logic        ferr_q;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [7:0]  data_q,     data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        parity_err_q, parity_err_d;
    logic        frame_err_q,  frame_err_d;
    logic        overrun_q,    overrun_d;
    logic [31:0] rdata_q,    rdata_d;

    logic [13:0] div_eff;
    logic [13:0] half_cnt;
    logic        tick;
    logic        fall;
    logic        complete;
    logic        ferr_now;
    logic        data_rd;
    logic        stat_rd;
    logic        unused_addr;

    assign div_eff     = (baud_divisor < 14'd2) ? 14'd2 : baud_divisor;
    assign half_cnt    = div_eff >> 1;
    assign tick        = (cnt_q == div_eff - 14'd1);
    assign fall        = rx_prev_q & ~rx_s2_q;
    assign complete    = Rx_en & tick &
                         (((state_q == STOP1) & ~Two_stop) | (state_q == STOP2));
    // A low line on either stop bit marks the frame; STOP1's result is carried in ferr_q.
    assign ferr_now    = ((state_q == STOP2) & ferr_q) | ~rx_s2_q;
    assign data_rd     = rd_en & (addr[3:2] == 2'd0);
    assign stat_rd     = rd_en & (addr[3:2] == 2'd1);
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= Rx_in;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else if (!Rx_en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == half_cnt) begin
                        cnt_q <= '0;
                        if (!rx_s2_q) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                            perr_q  <= 1'b0;
                            ferr_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s2_q, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) state_q <= PARITY;
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                PARITY: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        perr_q  <= ((^shift_q) ^ rx_s2_q) != Odd_parity;
                        state_q <= STOP1;
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                STOP1: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        ferr_q  <= ~rx_s2_q;
                        state_q <= Two_stop ? STOP2 : IDLE;
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                STOP2: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_d       = data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        rdata_d      = rdata_q;

        if (rd_en) begin
            case (addr[3:2])
                2'd0:    rdata_d = {24'b0, data_q};
                2'd1:    rdata_d = {28'b0, overrun_q, frame_err_q, parity_err_q, rx_valid_q};
                default: rdata_d = '0;
            endcase
        end
        if (data_rd) rx_valid_d = 1'b0;
        if (stat_rd) begin
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
        end
        // Completion is applied last so a same-cycle frame beats the read's clears.
        if (complete) begin
            data_d     = shift_q;
            rx_valid_d = 1'b1;
            if (perr_q)               parity_err_d = 1'b1;
            if (ferr_now)             frame_err_d  = 1'b1;
            if (rx_valid_q && !data_rd) overrun_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q       <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            data_q       <= data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            rdata_q      <= rdata_d;
        end
    end

    assign rdata    = rdata_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are bit-banged on Rx_in and results read
// back through the register window.
module tb_uart_rx;

    logic        clk;
    logic        reset;
    logic        Rx_in;
    logic [13:0] baud_divisor;
    logic        Rx_en;
    logic        Two_stop;
    logic        Odd_parity;
    logic [31:0] addr;
    logic        rd_en;
    logic [31:0] rdata;
    logic        rx_valid;

    int checks;
    int errors;

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .Rx_in        (Rx_in),
        .baud_divisor (baud_divisor),
        .Rx_en        (Rx_en),
        .Two_stop     (Two_stop),
        .Odd_parity   (Odd_parity),
        .addr         (addr),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rx_valid     (rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        Rx_in = b;
        repeat (int'(baud_divisor)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s1, input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s1);
        if (Two_stop) send_bit(s2);
        Rx_in = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        addr  = '0;
        v     = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_basic;
        logic [31:0] v;
        baud_divisor = 14'd4;
        Odd_parity   = 1'b0;
        Two_stop     = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_rx_valid: got %b expected 1", rx_valid);
        end
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL basic_status_pre: got %h expected %h", v, 32'h1);
        end
        do_read(32'h0, v);
        checks++;
        if (v !== 32'h000000A5) begin
            errors++;
            $display("FAIL basic_data: got %h expected %h", v, 32'h000000A5);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== 32'h000000A5) begin
            errors++;
            $display("FAIL basic_rdata_hold: got %h expected %h", rdata, 32'h000000A5);
        end
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL basic_status_post: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_parity;
        logic [31:0] v;
        Odd_parity = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h3) begin
            errors++;
            $display("FAIL parity_status1: got %h expected %h", v, 32'h3);
        end
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL parity_status2: got %h expected %h", v, 32'h1);
        end
        do_read(32'h0, v);
        checks++;
        if (v !== 32'h000000A5) begin
            errors++;
            $display("FAIL parity_data: got %h expected %h", v, 32'h000000A5);
        end
        Odd_parity = 1'b0;
    endtask

    task automatic test_frame_err;
        logic [31:0] v;
        Two_stop = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h5) begin
            errors++;
            $display("FAIL frame_err_status: got %h expected %h", v, 32'h5);
        end
        do_read(32'h0, v);
        checks++;
        if (v !== 32'h0000003C) begin
            errors++;
            $display("FAIL frame_err_data: got %h expected %h", v, 32'h0000003C);
        end
        Two_stop = 1'b0;
    endtask

    task automatic test_overrun;
        logic [31:0] v;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        do_read(32'h0, v);
        checks++;
        if (v !== 32'h00000022) begin
            errors++;
            $display("FAIL overrun_data: got %h expected %h", v, 32'h00000022);
        end
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL overrun_status: got %h expected %h", v, 32'h8);
        end
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL overrun_cleared: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_glitch;
        logic [31:0] v;
        baud_divisor = 14'd8;
        Rx_in = 1'b0;
        @(negedge clk);
        Rx_in = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_rx_valid: got %b expected 0", rx_valid);
        end
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL glitch_status: got %h expected %h", v, 32'h0);
        end
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        do_read(32'h0, v);
        checks++;
        if (v !== 32'h00000081) begin
            errors++;
            $display("FAIL glitch_followup_data: got %h expected %h", v, 32'h00000081);
        end
        do_read(32'h8, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL other_addr: got %h expected %h", v, 32'h0);
        end
        baud_divisor = 14'd4;
    endtask

    task automatic test_abort;
        logic [31:0] v;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        Rx_en = 1'b0;
        Rx_in = 1'b1;
        repeat (5) @(negedge clk);
        Rx_en = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_rx_valid: got %b expected 0", rx_valid);
        end
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL abort_status: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] v;
        logic [7:0]  d;
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        Rx_in = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (rdata !== 32'h0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_cleared: got rdata %h rx_valid %b expected 0/0", rdata, rx_valid);
        end
        repeat (20) @(negedge clk);
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        do_read(32'h0, v);
        checks++;
        if (v !== 32'h00000077) begin
            errors++;
            $display("FAIL midreset_data: got %h expected %h", v, 32'h00000077);
        end
        do_read(32'h4, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL midreset_status: got %h expected %h", v, 32'h0);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        Rx_in        = 1'b1;
        baud_divisor = 14'd4;
        Rx_en        = 1'b1;
        Two_stop     = 1'b0;
        Odd_parity   = 1'b0;
        addr         = '0;
        rd_en        = 1'b0;

        test_reset;
        test_basic;
        test_parity;
        test_frame_err;
        test_overrun;
        test_glitch;
        test_abort;
        test_reset_midframe;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Rx_in, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-004 SHALL have port baud_divisor, input, 14 bits: clocks per bit period; values 0 and 1 treated as 2.
REQ-005 SHALL have port Rx_en, input, 1 bit: receiver enable; 0 forces IDLE and ignores the line.
REQ-006 SHALL have port Two_stop, input, 1 bit: 1 = two stop bits expected, 0 = one.
REQ-007 SHALL have port Odd_parity, input, 1 bit: 1 = odd parity, 0 = even parity; parity bit always present.
REQ-008 SHALL have port addr, input, 32 bits: register address; only addr[3:2] decoded.
REQ-009 SHALL have port rd_en, input, 1 bit: register read strobe, one cycle.
REQ-010 SHALL have port rdata, output, 32 bits: read data, registered.
REQ-011 SHALL have port rx_valid, output, 1 bit: received byte waiting in data register.

Function
REQ-012 SHALL pass Rx_in through a two-flop synchronizer (reset value 1); all logic uses the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2 with a 14-bit bit-period counter and a 3-bit data index.
REQ-014 IDLE -> START on synchronized falling edge (1 then 0) while Rx_en=1; counter cleared.
REQ-015 START: at counter = baud_divisor>>1 (mid-bit), if line = 0 SHALL restart counter and go DATA; if line = 1 SHALL return to IDLE (glitch rejection, no flags set).
REQ-016 DATA/PARITY/STOP states SHALL sample once per full bit period (counter reaches baud_divisor-1 then wraps to 0).
REQ-017 DATA SHALL shift in 8 bits LSB first; after index 7 go PARITY.
REQ-018 PARITY: error if XOR(data bits, parity bit) != Odd_parity; go STOP1.
REQ-019 STOP1: sampled 0 sets frame_err; go STOP2 if Two_stop=1 else complete frame.
REQ-020 STOP2: sampled 0 sets frame_err; complete frame.
REQ-021 Frame completion SHALL load data register, set rx_valid, set parity_err if detected, return to IDLE, all in the same cycle.
REQ-022 If rx_valid is already 1 at completion, SHALL overwrite data register and set overrun.
REQ-023 Read addr[3:2]=0: rdata = {24'b0, data}, clears rx_valid; read addr[3:2]=1: rdata = {28'b0, overrun, frame_err, parity_err, rx_valid}, clears the three error flags; other addresses return 0.
REQ-024 rdata SHALL update on the cycle after rd_en (1-cycle latency) and hold until the next read.
REQ-025 Completion and data read in the same cycle: new byte wins, rx_valid stays 1, no overrun. Completion and status read in same cycle: new error flags win.
REQ-026 Rx_en deasserted mid-frame SHALL abort to IDLE with no register or flag update.
REQ-027 Error flags are sticky until status read or reset.

Reset
REQ-028 On reset SHALL go IDLE; counter, index, shift register, data register = 0; rx_valid, parity_err, frame_err, overrun = 0; rdata = 0; synchronizer flops = 1.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, reception resumes only on a new falling edge.

Verification
REQ-030 baud_divisor=4, Odd_parity=0, Two_stop=0, frame 0xA5 parity 0 stop 1 -> rx_valid=1; data read returns 0x000000A5; status 0x0.
REQ-031 Odd_parity=1, frame 0xA5 with parity bit 0 -> status read returns 0x3 (parity_err, rx_valid); second status read returns 0x1.
REQ-032 Two_stop=1, byte 0x3C, second stop bit driven 0 -> frame_err set, status bit 2 = 1.
REQ-033 Two frames 0x11 then 0x22 without read -> data read returns 0x22, status bit 3 (overrun) = 1.
REQ-034 Rx_in low pulse of 1 clock with baud_divisor=8 -> state returns to IDLE, rx_valid stays 0.
REQ-035 Reset pulse during DATA of 0x5A, then clean 0x77 frame -> only 0x77 received, no error flags.
